// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between two requesters, the arbiter and memory.
// Ports: MIPS (m_*), AXI (a_*), memory (mem_*), mips_rst, conflict_cnt.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 13
);
  localparam int AW = ADDR_WIDTH - 2;

  logic          mips_rst;

  logic          m_valid;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic          m_ready;
  logic          m_rvalid;
  logic [31:0]   m_rdata;

  logic          a_valid;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [31:0]   a_wdata;
  logic          a_ready;
  logic          a_rvalid;
  logic [31:0]   a_rdata;

  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [31:0]   mem_rdata;

  logic [31:0]   conflict_cnt;

  modport master (
    output mips_rst,
    output m_valid, m_we, m_addr, m_wdata,
    input  m_ready, m_rvalid, m_rdata,
    output a_valid, a_we, a_addr, a_wdata,
    input  a_ready, a_rvalid, a_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata,
    input  conflict_cnt
  );

  modport slave (
    input  mips_rst,
    input  m_valid, m_we, m_addr, m_wdata,
    output m_ready, m_rvalid, m_rdata,
    input  a_valid, a_we, a_addr, a_wdata,
    output a_ready, a_rvalid, a_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata,
    output conflict_cnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between MIPS and AXI.
// Ports: clk, rst (async, active-high), bus (mem_port_arbiter_if.slave).
// Optional macro ARB_CONFLICT_CNT_EN builds the wait-cycle counter.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 13
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int AW = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE,
    GNT_M,
    GNT_A,
    RESP
  } state_t;

  state_t state;
  logic   last_m;
  logic   resp_m;

  logic m_elig;
  logic gnt_m;
  logic gnt_a;
  logic rsp;

  assign m_elig = bus.m_valid & ~bus.mips_rst;
  assign gnt_m  = (state == GNT_M);
  assign gnt_a  = (state == GNT_A);
  assign rsp    = (state == RESP);

  // last_m resets to 0 (AXI) so MIPS wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      last_m <= 1'b0;
      resp_m <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (m_elig && (!bus.a_valid || !last_m))
            state <= GNT_M;
          else if (bus.a_valid)
            state <= GNT_A;
        end
        GNT_M: begin
          last_m <= 1'b1;
          resp_m <= 1'b1;
          state  <= bus.m_we ? IDLE : RESP;
        end
        GNT_A: begin
          last_m <= 1'b0;
          resp_m <= 1'b0;
          state  <= bus.a_we ? IDLE : RESP;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory side is AND-masked so it is all zero outside grant cycles.
  assign bus.mem_addr  = ({AW{gnt_m}} & bus.m_addr)
                       | ({AW{gnt_a}} & bus.a_addr);
  assign bus.mem_wdata = ({32{gnt_m}} & bus.m_wdata)
                       | ({32{gnt_a}} & bus.a_wdata);
  assign bus.mem_we    = (gnt_m & bus.m_we)
                       | (gnt_a & bus.a_we);
  assign bus.mem_re    = (gnt_m & ~bus.m_we)
                       | (gnt_a & ~bus.a_we);

  assign bus.m_ready  = gnt_m;
  assign bus.a_ready  = gnt_a;
  assign bus.m_rvalid = rsp & resp_m;
  assign bus.a_rvalid = rsp & ~resp_m;
  assign bus.m_rdata  = {32{bus.m_rvalid}} & bus.mem_rdata;
  assign bus.a_rdata  = {32{bus.a_rvalid}} & bus.mem_rdata;

`ifdef ARB_CONFLICT_CNT_EN
  logic [31:0] cnt;
  logic        wait_hit;

  // The non-owner is waiting for the whole grant+response window.
  assign wait_hit = ((gnt_m | (rsp & resp_m)) & bus.a_valid)
                  | ((gnt_a | (rsp & ~resp_m)) & m_elig);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (wait_hit)
      cnt <= cnt + 32'd1;
  end

  assign bus.conflict_cnt = cnt;
`else
  assign bus.conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-timeline model.
// Directed scenarios pin the model with literal expectations.
module tb_mem_port_arbiter;
  localparam int AW = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(13)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(13)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Ideal memory: read data one cycle after mem_re.
  bit [31:0] mem [2048];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
  end

  int checks = 0;
  int errors = 0;
  int cur = 0;

  // Model: one transaction at a time, described by its grant cycle.
  bit [31:0]     ref_mem [2048];
  int            gnt_cyc = -100;
  int            busy_end = 0;
  bit            owner_m, rd, last_m;
  logic [AW-1:0] gaddr;
  logic [31:0]   gwdata, rdexp, exp_cnt;

  // Requester drivers
  bit pend_m, pend_a, acc_m, acc_a;
  bit allow_m, allow_a, rd_only, rand_mrst;
  int rate;

  // Grant order recording
  bit rec;
  int n_gnt, n_alt;
  bit prev_g_m;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cur, act, exp);
    end
  endtask

  task automatic put_m(bit we, logic [AW-1:0] addr, logic [31:0] d);
    pend_m = 1'b1;
    bus.m_valid = 1'b1;
    bus.m_we = we;
    bus.m_addr = addr;
    bus.m_wdata = d;
  endtask

  task automatic put_a(bit we, logic [AW-1:0] addr, logic [31:0] d);
    pend_a = 1'b1;
    bus.a_valid = 1'b1;
    bus.a_we = we;
    bus.a_addr = addr;
    bus.a_wdata = d;
  endtask

  task automatic drive();
    if (acc_m) begin pend_m = 1'b0; bus.m_valid = 1'b0; end
    if (acc_a) begin pend_a = 1'b0; bus.a_valid = 1'b0; end
    if (!pend_m && allow_m && $urandom_range(99) < rate)
      put_m(rd_only ? 1'b0 : 1'($urandom_range(1)),
            AW'($urandom_range(15)), $urandom);
    if (!pend_a && allow_a && $urandom_range(99) < rate)
      put_a(rd_only ? 1'b0 : 1'($urandom_range(1)),
            AW'($urandom_range(15)), $urandom);
    if (rand_mrst && $urandom_range(19) == 0)
      bus.mips_rst = ~bus.mips_rst;
  endtask

  task automatic chk();
    bit g, r, me, ae;
    if (rst) begin
      check("rst_m_ready", 32'(bus.m_ready), 0);
      check("rst_a_ready", 32'(bus.a_ready), 0);
      check("rst_m_rvalid", 32'(bus.m_rvalid), 0);
      check("rst_a_rvalid", 32'(bus.a_rvalid), 0);
      check("rst_mem_we", 32'(bus.mem_we), 0);
      check("rst_mem_re", 32'(bus.mem_re), 0);
      check("rst_mem_addr", 32'(bus.mem_addr), 0);
      check("rst_cnt", bus.conflict_cnt, 0);
      gnt_cyc = -100;
      busy_end = cur + 1;
      rd = 1'b0;
      last_m = 1'b0;
      exp_cnt = 0;
      acc_m = 1'b0;
      acc_a = 1'b0;
      return;
    end
    g = (cur == gnt_cyc);
    r = rd && (cur == gnt_cyc + 1);
    if (g) begin
      rdexp = ref_mem[gaddr];
      if (!rd) ref_mem[gaddr] = gwdata;
    end
    check("m_ready", 32'(bus.m_ready), 32'(g && owner_m));
    check("a_ready", 32'(bus.a_ready), 32'(g && !owner_m));
    check("m_rvalid", 32'(bus.m_rvalid), 32'(r && owner_m));
    check("a_rvalid", 32'(bus.a_rvalid), 32'(r && !owner_m));
    check("m_rdata", bus.m_rdata, (r && owner_m) ? rdexp : 0);
    check("a_rdata", bus.a_rdata, (r && !owner_m) ? rdexp : 0);
    check("mem_addr", 32'(bus.mem_addr), g ? 32'(gaddr) : 0);
    check("mem_wdata", bus.mem_wdata, g ? gwdata : 0);
    check("mem_we", 32'(bus.mem_we), 32'(g && !rd));
    check("mem_re", 32'(bus.mem_re), 32'(g && rd));
    check("conflict_cnt", bus.conflict_cnt, exp_cnt);
    acc_m = g && owner_m;
    acc_a = g && !owner_m;
    if (rec && (bus.m_ready || bus.a_ready)) begin
      if (n_gnt > 0 && bus.m_ready != prev_g_m) n_alt++;
      prev_g_m = bus.m_ready;
      n_gnt++;
    end
    me = bus.m_valid && !bus.mips_rst;
    ae = bus.a_valid;
`ifdef ARB_CONFLICT_CNT_EN
    if (cur >= gnt_cyc && cur < busy_end)
      if (owner_m ? ae : me) exp_cnt = exp_cnt + 1;
`endif
    if (cur >= busy_end && (me || ae)) begin
      owner_m = (me && ae) ? !last_m : me;
      last_m = owner_m;
      rd = owner_m ? !bus.m_we : !bus.a_we;
      gaddr = owner_m ? bus.m_addr : bus.a_addr;
      gwdata = owner_m ? bus.m_wdata : bus.a_wdata;
      gnt_cyc = cur + 1;
      busy_end = cur + (rd ? 3 : 2);
    end
  endtask

  task automatic pre();
    @(posedge clk);
    #1;
    cur++;
    drive();
  endtask

  task automatic post();
    #1;
    chk();
  endtask

  task automatic step();
    pre();
    post();
  endtask

  task automatic do_rst();
    pre(); rst = 1'b1; post();
    step();
    pre(); rst = 1'b0; post();
  endtask

  logic [31:0] exp_b;
  bit seen_mr, seen_arv;

  initial begin
    bus.mips_rst = 0;
    bus.m_valid = 0; bus.m_we = 0; bus.m_addr = '0; bus.m_wdata = '0;
    bus.a_valid = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
    exp_cnt = 0;
    rate = 0;
    do_rst();

    // Preload 0x10 via AXI, then the single MIPS read.
    pre(); put_a(1'b1, 11'h010, 32'hDEADBEEF); post();
    step();
    check("pre_a_ready", 32'(bus.a_ready), 1);
    check("pre_mem_we", 32'(bus.mem_we), 1);
    step();
    pre(); put_m(1'b0, 11'h010, 32'h0); post();
    step();
    check("rd_m_ready", 32'(bus.m_ready), 1);
    check("rd_mem_re", 32'(bus.mem_re), 1);
    check("rd_mem_addr", 32'(bus.mem_addr), 32'h010);
    step();
    check("rd_m_rvalid", 32'(bus.m_rvalid), 1);
    check("rd_m_rdata", bus.m_rdata, 32'hDEADBEEF);
    step();

    // Simultaneous writes right after reset.
    do_rst();
    pre();
    put_m(1'b1, 11'h004, 32'h11111111);
    put_a(1'b1, 11'h008, 32'h22222222);
    post();
    step();
    check("sim_m_first", 32'(bus.m_ready), 1);
    check("sim_a_waits", 32'(bus.a_ready), 0);
    step();
    step();
    check("sim_a_second", 32'(bus.a_ready), 1);
    check("sim_a_addr", 32'(bus.mem_addr), 32'h008);
    step();
`ifdef ARB_CONFLICT_CNT_EN
    exp_b = 32'd1;
`else
    exp_b = 32'd0;
`endif
    check("sim_conflict", bus.conflict_cnt, exp_b);

    // MIPS held in reset: only AXI is served.
    pre();
    bus.mips_rst = 1'b1;
    put_m(1'b0, 11'h000, 32'h0);
    put_a(1'b0, 11'h000, 32'h0);
    post();
    seen_mr = 0;
    seen_arv = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.m_ready) seen_mr = 1;
      if (bus.a_rvalid) seen_arv = 1;
    end
    check("mrst_no_m_ready", 32'(seen_mr), 0);
    check("mrst_axi_served", 32'(seen_arv), 1);
    pre();
    bus.m_valid = 1'b0;
    pend_m = 1'b0;
    bus.mips_rst = 1'b0;
    post();

    // Continuous reads from both sides alternate.
    rd_only = 1; rate = 100; allow_m = 1; allow_a = 1;
    rec = 1; n_gnt = 0; n_alt = 0;
    repeat (30) step();
    allow_m = 0; allow_a = 0;
    repeat (10) step();
    rec = 0;
    check("rr_alternate", n_alt, n_gnt - 1);
    check("rr_enough", 32'(n_gnt >= 8), 1);

    // Reset while an AXI read is in its response cycle.
    pre(); put_a(1'b0, 11'h005, 32'h0); post();
    step();
    check("rr_rst_a_ready", 32'(bus.a_ready), 1);
    pre(); rst = 1'b1; post();
    check("rst_resp_rvalid", 32'(bus.a_rvalid), 0);
    pre(); rst = 1'b0; post();
    check("post_rst_rvalid", 32'(bus.a_rvalid), 0);
    check("post_rst_re", 32'(bus.mem_re), 0);
    check("post_rst_rdata", bus.a_rdata, 0);
    repeat (3) step();

    // Randomized traffic with a reset pulse in the middle.
    rd_only = 0; rate = 40; allow_m = 1; allow_a = 1; rand_mrst = 1;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        pre(); rst = 1'b1; post();
        pre(); rst = 1'b0; post();
      end else begin
        step();
      end
    end
    allow_m = 0; allow_a = 0; rand_mrst = 0;
    pre(); bus.mips_rst = 1'b0; post();
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 13, byte-address width of the 8KB ideal memory; every word address port below is ADDR_WIDTH-2 bits wide.
REQ-002 Clock and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  sole clock; every register updates on the rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 mips_rst  in  1  MIPS core held in reset; while high, MIPS requests are ignored.
REQ-006 m_valid, m_we  in  1 each  MIPS request valid; 1 = write, 0 = read.
REQ-007 m_addr  in  ADDR_WIDTH-2  MIPS word address; m_wdata  in  32  MIPS write data.
REQ-008 m_ready  out  1  MIPS request accepted; m_rvalid  out  1  MIPS read data valid; m_rdata  out  32.
REQ-009 a_valid, a_we, a_addr, a_wdata, a_ready, a_rvalid, a_rdata: AXI-side port, same widths and meanings as the MIPS port.
REQ-010 mem_addr  out  ADDR_WIDTH-2; mem_wdata  out  32; mem_we  out  1; mem_re  out  1; mem_rdata  in  32, valid one cycle after mem_re.
REQ-011 conflict_cnt  out  32  count of cycles in which a requester waited while the other was granted.

Function
REQ-012 The FSM SHALL have the states IDLE, GNT_M, GNT_A and RESP.
REQ-013 IDLE: if exactly one eligible request is present, go to its GNT state; if both are present, grant the requester not granted last (round-robin); with none, stay in IDLE.
REQ-014 A MIPS request is eligible only when m_valid=1 and mips_rst=0.
REQ-015 In GNT_x, the block SHALL drive mem_addr/mem_wdata/mem_we/mem_re combinationally from x's inputs, assert x_ready for exactly that one cycle, and update last-granted to x.
REQ-016 In GNT_x, mem_we=x_we and mem_re=~x_we.
REQ-017 From GNT_x: a write returns to IDLE; a read goes to RESP.
REQ-018 In RESP, the block SHALL assert x_rvalid for exactly one cycle, with x_rdata equal to mem_rdata, then return to IDLE.
REQ-019 Latency: read request seen in IDLE at cycle 0 gives ready at cycle 1 and rvalid at cycle 2; write gives ready at cycle 1 and mem_we at cycle 1.
REQ-020 Requesters hold valid/we/addr/wdata stable until ready; behaviour is undefined otherwise.
REQ-021 Outside GNT states, mem_* outputs SHALL be all zero (AND-masked).
REQ-022 x_rdata SHALL be zero except while x_rvalid is high.
REQ-023 Requests arriving in a GNT or RESP state SHALL wait; they are evaluated in the next IDLE.
REQ-024 mips_rst rising while MIPS is granted or in RESP SHALL NOT abort the transaction in progress.
REQ-025 mips_rst does not affect the AXI port.

Reset
REQ-026 rst SHALL asynchronously force state=IDLE and last-granted=AXI, so MIPS wins the first contention.
REQ-027 rst SHALL clear all ready/rvalid/mem_* outputs to 0 and conflict_cnt to 0.
REQ-028 rst mid-transaction SHALL drop the transaction: no ready or rvalid is issued afterwards for it.

Configuration
REQ-029 Macro ARB_CONFLICT_CNT_EN: when defined, conflict_cnt increments by 1 in each cycle that state is GNT_M/RESP-for-MIPS with a_valid=1, or GNT_A/RESP-for-AXI with an eligible MIPS request.
REQ-030 conflict_cnt wraps from 0xFFFFFFFF to 0.
REQ-031 When ARB_CONFLICT_CNT_EN is not defined, conflict_cnt SHALL be constant 0 and no counter register is built.

Verification
REQ-032 Single MIPS read: m_valid=1, m_we=0, m_addr=0x010, memory word 0x10 = 0xDEADBEEF -> m_ready cycle 1, mem_re=1 with mem_addr=0x010 at cycle 1, m_rvalid=1 and m_rdata=0xDEADBEEF at cycle 2.
REQ-033 Simultaneous requests after reset: MIPS write 0x11111111 to 0x4 and AXI write 0x22222222 to 0x8 -> MIPS granted first, AXI granted second; conflict_cnt=1 with the macro defined, 0 without it.
REQ-034 Round-robin: both requesters issue continuous reads -> grants alternate M,A,M,A and no requester waits more than one transaction.
REQ-035 mips_rst=1 with m_valid=1 and an AXI read to 0x0 -> only the AXI read is served and m_ready stays 0.
REQ-036 rst pulse in RESP of an AXI read -> a_rvalid never asserts, state=IDLE, and all outputs are 0 on the next cycle.
